// File: rtl/fault_report_tx_pkg.sv
// fault_codes_pkg: detector event codes, message classes and the message byte ROM.
package fault_codes_pkg;

  localparam logic [4:0] CODE_NONE = 5'd0;
  localparam logic [4:0] CODE_ESU1 = 5'd1;
  localparam logic [4:0] CODE_ESU2 = 5'd2;
  localparam logic [4:0] CODE_ESU3 = 5'd3;
  localparam logic [4:0] CODE_CSU1 = 5'd4;
  localparam logic [4:0] CODE_CSU2 = 5'd5;
  localparam logic [4:0] CODE_CSU3 = 5'd6;
  localparam logic [4:0] CODE_RSU1 = 5'd7;
  localparam logic [4:0] CODE_RSU2 = 5'd8;
  localparam logic [4:0] CODE_RSU3 = 5'd9;
  localparam logic [4:0] CODE_RSU4 = 5'd10;
  localparam logic [4:0] CODE_B1   = 5'd11;
  localparam logic [4:0] CODE_B2   = 5'd12;
  localparam logic [4:0] CODE_B3   = 5'd13;
  localparam logic [4:0] CODE_B4   = 5'd14;
  localparam logic [4:0] CODE_BDM  = 5'd15;
  localparam logic [4:0] CODE_STOP = 5'd31;

  // Message lengths in bytes, '#' included: "FIM-x<n>-#", "PB-B<n>-#", "BDM-#"/"END-#".
  localparam logic [3:0] MSG_LEN_FIM   = 4'd8;
  localparam logic [3:0] MSG_LEN_PB    = 4'd7;
  localparam logic [3:0] MSG_LEN_SHORT = 4'd5;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_E,
    CLS_C,
    CLS_R,
    CLS_B,
    CLS_BDM,
    CLS_END
  } msg_class_e;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_SEND,
    SND_WAIT
  } snd_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_e;

  // Unmapped codes (0 and 16..30) fall into CLS_NONE.
  function automatic msg_class_e code_class(input logic [4:0] code);
    msg_class_e c;
    case (code)
      CODE_ESU1, CODE_ESU2, CODE_ESU3:            c = CLS_E;
      CODE_CSU1, CODE_CSU2, CODE_CSU3:            c = CLS_C;
      CODE_RSU1, CODE_RSU2, CODE_RSU3, CODE_RSU4: c = CLS_R;
      CODE_B1, CODE_B2, CODE_B3, CODE_B4:         c = CLS_B;
      CODE_BDM:                                   c = CLS_BDM;
      CODE_STOP:                                  c = CLS_END;
      default:                                    c = CLS_NONE;
    endcase
    return c;
  endfunction

  // ASCII digit giving the sensor number within its class.
  function automatic logic [7:0] code_digit(input logic [4:0] code);
    logic [7:0] d;
    case (code)
      CODE_ESU1, CODE_CSU1, CODE_RSU1, CODE_B1: d = "1";
      CODE_ESU2, CODE_CSU2, CODE_RSU2, CODE_B2: d = "2";
      CODE_ESU3, CODE_CSU3, CODE_RSU3, CODE_B3: d = "3";
      CODE_RSU4, CODE_B4:                       d = "4";
      default:                                  d = "0";
    endcase
    return d;
  endfunction

  function automatic logic [3:0] msg_len(input logic [4:0] code);
    logic [3:0] n;
    case (code_class(code))
      CLS_E, CLS_C, CLS_R: n = MSG_LEN_FIM;
      CLS_B:               n = MSG_LEN_PB;
      CLS_BDM, CLS_END:    n = MSG_LEN_SHORT;
      default:             n = 4'd0;
    endcase
    return n;
  endfunction

  // Byte ROM addressed by {class, byte index}; the digit slot is filled from the code.
  function automatic logic [7:0] msg_byte(input logic [4:0] code, input logic [3:0] idx);
    msg_class_e cls;
    logic [7:0] b;
    cls = code_class(code);
    b = "#";
    case (cls)
      CLS_E, CLS_C, CLS_R: begin
        case (idx)
          4'd0:    b = "F";
          4'd1:    b = "I";
          4'd2:    b = "M";
          4'd3:    b = "-";
          4'd4:    b = (cls == CLS_E) ? "E" : ((cls == CLS_C) ? "C" : "R");
          4'd5:    b = code_digit(code);
          4'd6:    b = "-";
          default: b = "#";
        endcase
      end
      CLS_B: begin
        case (idx)
          4'd0:    b = "P";
          4'd1:    b = "B";
          4'd2:    b = "-";
          4'd3:    b = "B";
          4'd4:    b = code_digit(code);
          4'd5:    b = "-";
          default: b = "#";
        endcase
      end
      CLS_BDM: begin
        case (idx)
          4'd0:    b = "B";
          4'd1:    b = "D";
          4'd2:    b = "M";
          4'd3:    b = "-";
          default: b = "#";
        endcase
      end
      CLS_END: begin
        case (idx)
          4'd0:    b = "E";
          4'd1:    b = "N";
          4'd2:    b = "D";
          4'd3:    b = "-";
          default: b = "#";
        endcase
      end
      default: b = "#";
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fault_report_tx_if.sv
// fault_report_tx_if: 4-phase req/ack event channel from the fault/column detector.
interface fault_report_tx_if;
  logic [4:0] fault_code;
  logic       req;
  logic       ack;

  modport master (output fault_code, output req, input ack);
  modport slave  (input fault_code, input req, output ack);
endinterface

// File: rtl/fault_report_tx_uart.sv
// uart_tx_byte: 8N1 serialiser, one byte per start strobe, done at the end of the stop bit.
module uart_tx_byte
  import fault_codes_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state;
  uart_state_e      state_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_p0;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  // state register; reset drops the line back to idle mid-frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= U_IDLE;
    else       state <= state_nxt;
  end

  // next-state: start bit, eight data bits, stop bit, each one baud period
  always_comb begin
    state_nxt = state;
    case (state)
      U_IDLE:  if (start) state_nxt = U_START;
      U_START: if (bit_end) state_nxt = U_DATA;
      U_DATA:  if (bit_end && (bit_cnt == 3'd7)) state_nxt = U_STOP;
      U_STOP:  if (bit_end) state_nxt = U_IDLE;
      default: state_nxt = U_IDLE;
    endcase
  end

  // baud and bit counters, both parked at zero while idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
    end else begin
      if ((state == U_IDLE) || bit_end) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + 1'b1;
      if (state == U_IDLE)                     bit_cnt <= 3'd0;
      else if ((state == U_DATA) && bit_end)   bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // shift register: loaded on start, LSB goes out first
  always_ff @(posedge clock) begin
    if ((state == U_IDLE) && start)        shift_p0 <= data;
    else if ((state == U_DATA) && bit_end) shift_p0 <= {1'b0, shift_p0[7:1]};
  end

  // outputs decoded from the state so tx follows reset without a clock
  always_comb begin
    tx   = 1'b1;
    done = 1'b0;
    busy = 1'b1;
    case (state)
      U_IDLE:  busy = 1'b0;
      U_START: tx = 1'b0;
      U_DATA:  tx = shift_p0[0];
      U_STOP:  done = bit_end;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/fault_report_tx.sv
// fault_report_tx: receives detector events over req/ack, filters repeats,
// and sends each new event as an ASCII message on the UART line.
module fault_report_tx
  import fault_codes_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  fault_report_tx_if.slave   rpt,
  output logic               tx,
  output logic               busy,
  output logic               dropped
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic                   ack_q;
  logic                   lat_vld_p0;
  logic [4:0]             lat_code_p0;
  logic [4:0]             last_code;
  logic                   post;
  logic                   pend_full;
  logic [4:0]             pend_code;
  logic                   consume;
  snd_state_e             snd_state;
  snd_state_e             snd_nxt;
  logic [4:0]             msg_code;
  logic [3:0]             msg_len_q;
  logic [3:0]             idx;
  logic                   last_byte;
  logic                   byte_start;
  logic [7:0]             byte_data;
  logic                   byte_done;
  logic                   byte_busy;

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign rpt.ack  = ack_q;

  // req arrives from the detector's opposite-edge domain: resynchronise it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) req_sync <= '0;
    else       req_sync <= {req_sync[SYNC_STAGES-2:0], rpt.req};
  end

  // handshake receiver: exactly one latch strobe per req pulse, ack held until req drops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      lat_vld_p0 <= 1'b0;
    end else begin
      lat_vld_p0 <= 1'b0;
      if (!ack_q && req_s) begin
        ack_q      <= 1'b1;
        lat_vld_p0 <= 1'b1;
      end else if (ack_q && !req_s) begin
        ack_q <= 1'b0;
      end
    end
  end

  // code capture travels with the latch strobe; the detector holds it stable while req is high
  always_ff @(posedge clock) begin
    if (!ack_q && req_s) lat_code_p0 <= rpt.fault_code;
  end

  // a latched code is reported only if it is mapped and differs from the last reported one
  assign post = lat_vld_p0 && (code_class(lat_code_p0) != CLS_NONE) && (lat_code_p0 != last_code);

  // repeat filter: NONE re-arms it, unmapped codes leave it untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_code <= CODE_NONE;
    end else if (lat_vld_p0) begin
      if (lat_code_p0 == CODE_NONE) last_code <= CODE_NONE;
      else if (post)                last_code <= lat_code_p0;
    end
  end

  // pending slot flag: newest post wins; a same-cycle consume frees room so nothing is dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_full <= 1'b0;
      dropped   <= 1'b0;
    end else if (post) begin
      pend_full <= 1'b1;
      if (pend_full && !consume) dropped <= 1'b1;
    end else if (consume) begin
      pend_full <= 1'b0;
    end
  end

  // pending slot contents
  always_ff @(posedge clock) begin
    if (post) pend_code <= lat_code_p0;
  end

  assign last_byte = ((idx + 4'd1) == msg_len_q);

  // sender state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) snd_state <= SND_IDLE;
    else       snd_state <= snd_nxt;
  end

  // sender next-state: take a pending code, then hand bytes to the UART one at a time
  always_comb begin
    snd_nxt = snd_state;
    case (snd_state)
      SND_IDLE: if (pend_full) snd_nxt = SND_SEND;
      SND_SEND: snd_nxt = SND_WAIT;
      SND_WAIT: if (byte_done) snd_nxt = last_byte ? SND_IDLE : SND_SEND;
      default:  snd_nxt = SND_IDLE;
    endcase
  end

  // sender outputs: slot consume in IDLE, byte strobe in SEND
  always_comb begin
    consume    = 1'b0;
    byte_start = 1'b0;
    case (snd_state)
      SND_IDLE: consume = pend_full;
      SND_SEND: byte_start = 1'b1;
      default: ;
    endcase
  end

  // message length and byte index for the message in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx       <= 4'd0;
      msg_len_q <= 4'd0;
    end else if (consume) begin
      idx       <= 4'd0;
      msg_len_q <= msg_len(pend_code);
    end else if ((snd_state == SND_WAIT) && byte_done) begin
      idx <= idx + 4'd1;
    end
  end

  // code of the message in flight
  always_ff @(posedge clock) begin
    if (consume) msg_code <= pend_code;
  end

  assign byte_data = msg_byte(msg_code, idx);
  assign busy      = (snd_state != SND_IDLE) | pend_full | byte_busy;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock (clock),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done),
    .busy  (byte_busy)
  );

endmodule

// File: tb/tb_fault_report_tx.sv
// tb_fault_report_tx: directed handshake stimulus with a UART line decoder.
module tb_fault_report_tx;
  import fault_codes_pkg::*;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int SYNC    = 2;
  localparam int GAP_MAX = 10 * CPB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic busy;
  logic dropped;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          frame_err = 0;
  int unsigned cyc       = 0;
  int unsigned prev_t    = 0;
  logic [7:0]  rx_q[$];
  int unsigned rx_t[$];

  fault_report_tx_if rpt ();

  fault_report_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clk),
    .reset(rst),
    .rpt(rpt),
    .tx(tx),
    .busy(busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // line decoder: samples mid-bit, records each byte with its start-edge cycle
  initial begin : uart_rx
    logic [7:0]  d;
    int unsigned t0;
    logic        start_bit;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        start_bit = tx;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          d[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (start_bit !== 1'b0 || tx !== 1'b1) frame_err++;
        rx_q.push_back(d);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic send_code(input logic [4:0] code, input bit check_lat);
    int k;
    @(negedge clk);
    rpt.fault_code = code;
    rpt.req = 1'b1;
    k = 0;
    while (rpt.ack !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("ack_rise", 32'(rpt.ack), 32'd1);
    if (check_lat) check_val("ack_rise_lat", 32'(k), 32'(SYNC + 1));
    rpt.req = 1'b0;
    k = 0;
    while (rpt.ack !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("ack_fall", 32'(rpt.ack), 32'd0);
    if (check_lat) check_val("ack_fall_lat", 32'(k), 32'(SYNC + 1));
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_arrived"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic expect_msg(input string tag, input string exp, input bit chained);
    logic [7:0]  got;
    int unsigned t;
    wait_bytes(tag, exp.len(), exp.len() * (10 * CPB + 4) + 400);
    for (int i = 0; i < exp.len(); i++) begin
      if (rx_q.size() == 0) break;
      got = rx_q.pop_front();
      t   = rx_t.pop_front();
      check_val($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp[i]));
      if (i > 0 || chained)
        check_val($sformatf("%s_gap%0d", tag, i), 32'((t - prev_t) <= GAP_MAX), 32'd1);
      prev_t = t;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    repeat (cycles) @(negedge clk);
    check_val({tag, "_no_extra"}, 32'(rx_q.size()), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    rpt.req = 1'b0;
    rpt.fault_code = CODE_NONE;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ack", 32'(rpt.ack), 32'd0);
    check_val("rst_tx", 32'(tx), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_dropped", 32'(dropped), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single event, full message, busy drops after the final stop bit
    send_code(CODE_ESU2, 1'b1);
    check_val("esu2_busy", 32'(busy), 32'd1);
    expect_msg("esu2", "FIM-E2-#", 1'b0);
    check_val("esu2_busy_last", 32'(busy), 32'd1);
    repeat (CPB) @(negedge clk);
    check_val("esu2_busy_end", 32'(busy), 32'd0);

    // three identical events report once
    repeat (3) send_code(CODE_CSU2, 1'b0);
    expect_msg("c2x3", "FIM-C2-#", 1'b0);
    expect_quiet("c2x3", 40 * CPB);

    // NONE re-arms the filter: 0,5,0,5 gives two messages
    send_code(CODE_NONE, 1'b0);
    send_code(CODE_CSU2, 1'b0);
    send_code(CODE_NONE, 1'b0);
    send_code(CODE_CSU2, 1'b0);
    expect_msg("c505a", "FIM-C2-#", 1'b0);
    expect_msg("c505b", "FIM-C2-#", 1'b1);
    check_val("c505_dropped", 32'(dropped), 32'd0);
    expect_quiet("c505", 40 * CPB);

    // event queued during the third byte follows without a gap
    send_code(CODE_RSU1, 1'b0);
    wait_bytes("r1_lead", 2, 30 * CPB + 200);
    repeat (2 * CPB) @(negedge clk);
    send_code(CODE_B3, 1'b0);
    expect_msg("r1", "FIM-R1-#", 1'b0);
    expect_msg("b3", "PB-B3-#", 1'b1);
    check_val("b3_dropped", 32'(dropped), 32'd0);
    expect_quiet("b3", 40 * CPB);

    // two events during one message: newest wins, drop is flagged
    send_code(CODE_RSU3, 1'b0);
    wait_bytes("r3_lead", 2, 30 * CPB + 200);
    repeat (2 * CPB) @(negedge clk);
    send_code(CODE_B1, 1'b0);
    send_code(CODE_STOP, 1'b0);
    check_val("ovr_dropped", 32'(dropped), 32'd1);
    expect_msg("r3", "FIM-R3-#", 1'b0);
    expect_msg("end", "END-#", 1'b1);
    expect_quiet("end", 40 * CPB);
    check_val("end_dropped_sticky", 32'(dropped), 32'd1);

    // reset mid-byte with a handshake open, then the same code reports again
    send_code(CODE_BDM, 1'b0);
    wait_bytes("bdm_lead", 1, 20 * CPB + 200);
    repeat (3 * CPB) @(negedge clk);
    rpt.fault_code = CODE_BDM;
    rpt.req = 1'b1;
    k = 0;
    while (rpt.ack !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("pre_rst_ack", 32'(rpt.ack), 32'd1);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_tx", 32'(tx), 32'd1);
    check_val("mid_rst_ack", 32'(rpt.ack), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_dropped", 32'(dropped), 32'd0);
    rpt.req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rx_q.delete();
    rx_t.delete();
    frame_err = 0;
    check_val("post_rst_tx", 32'(tx), 32'd1);
    send_code(CODE_BDM, 1'b0);
    expect_msg("bdm", "BDM-#", 1'b0);
    expect_quiet("bdm", 40 * CPB);
    check_val("frame_err", 32'(frame_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
